uart_apb4_bridge: RTL and testbench
===================================

Name: uart_apb4_bridge

Overview:
- Byte-stream-to-APB4 initiator. Decodes command frames arriving as bytes (typically from a uart_rx instance), issues one APB4 read or write per frame as bus master, and returns status/data bytes on a byte output stream (typically to a uart_tx instance).
- Gives an external host debug access to on-chip APB slaves, including the UART register block, over a serial link.

Parameters:
- BYTE_TMO, 100000, inter-byte timeout in clk_i cycles while a frame is partially received; 0 disables.
- APB_TMO, 255, maximum ACCESS-phase cycles to wait for pready_i before aborting; must be ≥1.

Ports:
- clk_i  in  1  clock; also PCLK of the driven bus
- rst_n_i  in  1  asynchronous active-low reset
- rx_data_i  in  8  command byte stream data
- rx_valid_i  in  1  command byte valid
- rx_ready_o  out  1  bridge accepts command byte
- tx_data_o  out  8  response byte stream data
- tx_valid_o  out  1  response byte valid
- tx_ready_i  in  1  downstream accepts response byte
- paddr_o  out  32  APB address
- psel_o  out  1  APB select
- penable_o  out  1  APB enable
- pwrite_o  out  1  APB direction
- pwdata_o  out  32  APB write data
- pstrb_o  out  4  4'hF on writes, 4'h0 on reads
- pprot_o  out  3  constant 3'b000
- prdata_i  in  32  APB read data
- pready_i  in  1  APB ready
- pslverr_i  in  1  APB error
- busy_o  out  1  high in any state other than IDLE
- frame_err_o  out  1  one-cycle pulse on unknown command or inter-byte timeout

Behaviour:
- Byte handshake: transfer occurs when valid && ready at a rising edge.
- tx_data_o is held stable while tx_valid_o is high and tx_ready_i is low.
- Frame format, all multi-byte fields little-endian:
  - Write: 0x57 'W', 4 address bytes, 4 data bytes.
  - Read: 0x52 'R', 4 address bytes.
- Status codes: 0x4B 'K' OK, 0x45 'E' pslverr, 0x54 'T' APB timeout.
- Responses:
  - Write: status byte only.
  - Read: status byte, then 4 data bytes LE. Data bytes are 0x00 when status ≠ 'K'.
- FSM states: IDLE, ADDR, WDATA, SETUP, ACCESS, RESP.
  - IDLE: rx_ready_o=1.
    - 'W'/'R' latches direction and goes to ADDR.
    - Any other byte is dropped, pulses frame_err_o, and stays in IDLE.
  - ADDR: rx_ready_o=1. Shifts 4 bytes into paddr; byte n fills bits [8n+7:8n]. After the 4th byte goes to WDATA (write) or SETUP (read).
  - WDATA: rx_ready_o=1. Collects 4 bytes the same way, then goes to SETUP.
  - SETUP: exactly one cycle with psel_o=1, penable_o=0. paddr_o, pwrite_o, pwdata_o and pstrb_o are valid here and held stable through ACCESS.
  - ACCESS: psel_o=1, penable_o=1.
    - When pready_i=1, captures prdata_i (read) and pslverr_i, sets status to 'K' or 'E', and goes to RESP.
    - If pready_i stays low for APB_TMO consecutive ACCESS cycles, status='T' and the state goes to RESP.
    - psel_o and penable_o are 0 in the cycle after leaving ACCESS.
  - RESP: tx_valid_o=1. Emits 1 or 5 bytes under a 3-bit counter, then returns to IDLE.
- rx_ready_o=0 in SETUP, ACCESS and RESP. Host bytes are back-pressured, never dropped.
- Inter-byte timeout:
  - Counter is cleared on every accepted byte and runs only in ADDR/WDATA.
  - When it reaches BYTE_TMO: frame discarded, frame_err_o pulse, return to IDLE, no APB transfer, no response.
- Idle bus outputs: paddr_o, pwdata_o and pwrite_o keep their last values; psel_o=penable_o=0.
- Reset values: state IDLE; all outputs 0 except rx_ready_o=1 once reset is released.
- Reset mid-APB-transfer drops psel_o/penable_o immediately (asynchronous). No response is sent.
- Minimum latency: last frame byte accepted at cycle t; SETUP at t+1; ACCESS at t+2; with pready_i=1 at t+2, the first response byte is valid at t+3.

Decomposition:
- Add to uart_define.sv:
  - command constants UART_BRG_CMD_WR/RD
  - status constants UART_BRG_ST_OK/ERR/TMO
  - the bridge state enum typedef
- Counters use the existing dffr/dffer/dffrc register cells.
- No sub-module is natural; a single module of ~250 lines.

Test Plan:
1. Write: send 57 10 00 00 40 EF BE AD DE; slave pready=1 → one SETUP+ACCESS with paddr=0x40000010, pwdata=0xDEADBEEF, pstrb=F; response 4B.
2. Read: send 52 04 00 00 40; slave returns 0x12345678 after 3 wait states → ACCESS lasts 4 cycles; response 4B 78 56 34 12.
3. Read with pslverr=1 → response 45 00 00 00 00; write with pslverr=1 → 45.
4. APB_TMO=8, pready_i held 0 → penable_o high exactly 8 cycles; response 54; psel_o=0 afterwards.
5. BYTE_TMO=16: send 57 10 then stall 16 cycles → frame_err_o pulse, no APB activity; the next valid frame completes normally. Byte 0xAA in IDLE → frame_err_o pulse only.
6. tx_ready_i toggled randomly during a 5-byte read response → bytes in order, data stable while stalled; rx_valid_i asserted during RESP sees rx_ready_o=0. Reset asserted during ACCESS → psel_o=0 at once, no response.

Source files
------------

// File: rtl/uart_apb4_bridge_pkg.sv
// Shared constants and types for the byte-stream to APB4 bridge.
// Command and status codes are ASCII so a terminal host can drive the link directly.
package uart_apb4_bridge_pkg;

    localparam logic [7:0] UART_BRG_CMD_WR = 8'h57;  // 'W'
    localparam logic [7:0] UART_BRG_CMD_RD = 8'h52;  // 'R'
    localparam logic [7:0] UART_BRG_ST_OK  = 8'h4B;  // 'K'
    localparam logic [7:0] UART_BRG_ST_ERR = 8'h45;  // 'E'
    localparam logic [7:0] UART_BRG_ST_TMO = 8'h54;  // 'T'

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StWdata,
        StSetup,
        StAccess,
        StResp
    } brg_state_e;

    // Index of the final response byte: status only for writes, status + 4 data for reads.
    function automatic logic [2:0] brg_resp_last(input logic write);
        return write ? 3'd0 : 3'd4;
    endfunction

endpackage

// File: rtl/uart_apb4_bridge.sv
// Decodes 'W'/'R' command frames from a byte stream, performs one APB4 transfer per frame
// as bus master, and returns a status byte (plus read data) on the response stream.
module uart_apb4_bridge
    import uart_apb4_bridge_pkg::*;
#(
    parameter int unsigned BYTE_TMO = 100000,
    parameter int unsigned APB_TMO  = 255
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic [31:0] paddr_o,
    output logic        psel_o,
    output logic        penable_o,
    output logic        pwrite_o,
    output logic [31:0] pwdata_o,
    output logic [3:0]  pstrb_o,
    output logic [2:0]  pprot_o,
    input  logic [31:0] prdata_i,
    input  logic        pready_i,
    input  logic        pslverr_i,
    output logic        busy_o,
    output logic        frame_err_o
);

    brg_state_e  state_q, state_d;
    logic        write_q, write_d;
    logic [31:0] paddr_q, paddr_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] btmo_cnt_q, btmo_cnt_d;
    logic [31:0] atmo_cnt_q, atmo_cnt_d;
    logic [7:0]  status_q, status_d;
    logic [31:0] rdata_q, rdata_d;
    logic [2:0]  resp_cnt_q, resp_cnt_d;
    logic        frame_err_q, frame_err_d;
    logic        ready_en_q;

    logic rx_fire, tx_fire, collecting, byte_tmo_hit;

    assign rx_fire    = rx_valid_i && rx_ready_o;
    assign tx_fire    = tx_valid_o && tx_ready_i;
    assign collecting = (state_q == StAddr) || (state_q == StWdata);
    // A zero BYTE_TMO disables the inter-byte watchdog entirely.
    assign byte_tmo_hit = (BYTE_TMO != 0) && collecting && !rx_fire &&
                          (btmo_cnt_q + 32'd1 == BYTE_TMO);

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        byte_cnt_d  = byte_cnt_q;
        atmo_cnt_d  = atmo_cnt_q;
        status_d    = status_q;
        rdata_d     = rdata_q;
        resp_cnt_d  = resp_cnt_q;
        frame_err_d = 1'b0;
        btmo_cnt_d  = (collecting && !rx_fire) ? btmo_cnt_q + 32'd1 : 32'd0;

        unique case (state_q)
            StIdle: begin
                if (rx_fire) begin
                    if (rx_data_i == UART_BRG_CMD_WR || rx_data_i == UART_BRG_CMD_RD) begin
                        write_d    = (rx_data_i == UART_BRG_CMD_WR);
                        byte_cnt_d = 2'd0;
                        state_d    = StAddr;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            StAddr, StWdata: begin
                if (rx_fire) begin
                    if (state_q == StAddr) begin
                        paddr_d[{byte_cnt_q, 3'b000} +: 8] = rx_data_i;
                    end else begin
                        pwdata_d[{byte_cnt_q, 3'b000} +: 8] = rx_data_i;
                    end
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = (state_q == StAddr && write_q) ? StWdata : StSetup;
                    end
                end else if (byte_tmo_hit) begin
                    frame_err_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            StSetup: begin
                atmo_cnt_d = 32'd0;
                state_d    = StAccess;
            end
            StAccess: begin
                resp_cnt_d = 3'd0;
                if (pready_i) begin
                    status_d = pslverr_i ? UART_BRG_ST_ERR : UART_BRG_ST_OK;
                    rdata_d  = pslverr_i ? 32'd0 : prdata_i;
                    state_d  = StResp;
                end else if (atmo_cnt_q == APB_TMO - 1) begin
                    status_d = UART_BRG_ST_TMO;
                    rdata_d  = 32'd0;
                    state_d  = StResp;
                end else begin
                    atmo_cnt_d = atmo_cnt_q + 32'd1;
                end
            end
            StResp: begin
                if (tx_fire) begin
                    if (resp_cnt_q == brg_resp_last(write_q)) begin
                        state_d = StIdle;
                    end else begin
                        resp_cnt_d = resp_cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= StIdle;
            write_q     <= 1'b0;
            paddr_q     <= 32'd0;
            pwdata_q    <= 32'd0;
            byte_cnt_q  <= 2'd0;
            btmo_cnt_q  <= 32'd0;
            atmo_cnt_q  <= 32'd0;
            status_q    <= 8'd0;
            rdata_q     <= 32'd0;
            resp_cnt_q  <= 3'd0;
            frame_err_q <= 1'b0;
            ready_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            byte_cnt_q  <= byte_cnt_d;
            btmo_cnt_q  <= btmo_cnt_d;
            atmo_cnt_q  <= atmo_cnt_d;
            status_q    <= status_d;
            rdata_q     <= rdata_d;
            resp_cnt_q  <= resp_cnt_d;
            frame_err_q <= frame_err_d;
            ready_en_q  <= 1'b1;
        end
    end

    always_comb begin
        tx_data_o = 8'h00;
        unique case (resp_cnt_q)
            3'd0:    tx_data_o = status_q;
            3'd1:    tx_data_o = rdata_q[7:0];
            3'd2:    tx_data_o = rdata_q[15:8];
            3'd3:    tx_data_o = rdata_q[23:16];
            3'd4:    tx_data_o = rdata_q[31:24];
            default: tx_data_o = 8'h00;
        endcase
    end

    // ready_en_q keeps rx_ready_o low while reset is held.
    assign rx_ready_o  = ready_en_q && (state_q == StIdle || collecting);
    assign tx_valid_o  = (state_q == StResp);
    assign psel_o      = (state_q == StSetup) || (state_q == StAccess);
    assign penable_o   = (state_q == StAccess);
    assign pwrite_o    = write_q;
    assign paddr_o     = paddr_q;
    assign pwdata_o    = pwdata_q;
    assign pstrb_o     = write_q ? 4'hF : 4'h0;
    assign pprot_o     = 3'b000;
    assign busy_o      = (state_q != StIdle);
    assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_uart_apb4_bridge.sv
// Bench for uart_apb4_bridge: table vectors, hand-written corner sequences and random frames
// checked against a frame-level model of the command/response protocol.
module tb_uart_apb4_bridge;
    import uart_apb4_bridge_pkg::*;

    localparam int unsigned BTMO = 16;
    localparam int unsigned ATMO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] paddr, pwdata, prdata;
    logic        psel, penable, pwrite, pready, pslverr, busy, frame_err;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;

    always #5 clk = ~clk;

    uart_apb4_bridge #(.BYTE_TMO(BTMO), .APB_TMO(ATMO)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
        .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
        .paddr_o(paddr), .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
        .pwdata_o(pwdata), .pstrb_o(pstrb), .pprot_o(pprot),
        .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr),
        .busy_o(busy), .frame_err_o(frame_err)
    );

    // Behavioural APB slave: pready after slv_wait wait states.
    int unsigned slv_wait;
    logic        slv_err;
    logic [31:0] slv_rdata;
    int unsigned acc_cnt = 0;
    assign pready  = psel && penable && (acc_cnt == slv_wait);
    assign pslverr = slv_err;
    assign prdata  = slv_rdata;

    // Monotonic monitors; tests take differences of snapshots.
    int          cyc = 0, pen_total = 0, setup_total = 0, xfer_total = 0, fe_total = 0;
    int          rsp_wr = 0, stall_viol = 0, rxr_viol = 0;
    logic [7:0]  rsp_mem [0:1023];
    logic [31:0] cap_addr, cap_wdata;
    logic        cap_write;
    logic [3:0]  cap_strb;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data;
    bit          rand_mode = 1'b0;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        acc_cnt <= (psel && penable && !pready) ? acc_cnt + 1 : 0;
        if (psel && penable) pen_total <= pen_total + 1;
        if (psel && !penable) setup_total <= setup_total + 1;
        if (psel && penable && pready) begin
            cap_addr   <= paddr;
            cap_wdata  <= pwdata;
            cap_write  <= pwrite;
            cap_strb   <= pstrb;
            xfer_total <= xfer_total + 1;
        end
        if (frame_err) fe_total <= fe_total + 1;
        if (tx_valid && tx_ready) begin
            rsp_mem[rsp_wr % 1024] <= tx_data;
            rsp_wr <= rsp_wr + 1;
        end
        prev_stall <= tx_valid && !tx_ready;
        prev_data  <= tx_data;
        if (prev_stall && (!tx_valid || tx_data !== prev_data)) stall_viol <= stall_viol + 1;
        if (tx_valid && rx_ready) rxr_viol <= rxr_viol + 1;
    end

    always @(negedge clk) tx_ready <= rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int unsigned wait_st;
        bit          err;
        logic [7:0]  exp_st;
        logic [31:0] exp_data;
        int unsigned exp_pen;
    } vec_t;

    int n_vec = 0, n_err = 0;
    int acc_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_bound(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Frame-level reference: status from slave behaviour, data zeroed unless OK.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        r.exp_st   = (v.wait_st >= ATMO) ? UART_BRG_ST_TMO :
                     (v.err ? UART_BRG_ST_ERR : UART_BRG_ST_OK);
        r.exp_data = (r.exp_st == UART_BRG_ST_OK && !v.wr) ? v.rdata : 32'd0;
        r.exp_pen  = (v.wait_st >= ATMO) ? ATMO : v.wait_st + 1;
        return r;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int k = 0;
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) begin
            fail_bound("rx_accept");
            rx_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        acc_cyc  = cyc;
    endtask

    task automatic send_frame(input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
        send_byte(wr ? UART_BRG_CMD_WR : UART_BRG_CMD_RD);
        for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
        if (wr) for (int i = 0; i < 4; i++) send_byte(wdata[8*i +: 8]);
    endtask

    task automatic wait_rsp(input int base, input int n);
        int k = 0;
        while (rsp_wr < base + n && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (k >= 400) fail_bound("rsp_wait");
        k = 0;
        while (busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) fail_bound("idle_wait");
    endtask

    function automatic logic [31:0] rsp_word(input int base);
        return {rsp_mem[(base + 4) % 1024], rsp_mem[(base + 3) % 1024],
                rsp_mem[(base + 2) % 1024], rsp_mem[(base + 1) % 1024]};
    endfunction

    task automatic apply_txn(input vec_t v, input string tag);
        int s0, p0, x0, r0;
        slv_wait  = v.wait_st;
        slv_err   = v.err;
        slv_rdata = v.rdata;
        s0 = setup_total; p0 = pen_total; x0 = xfer_total; r0 = rsp_wr;
        send_frame(v.wr, v.addr, v.wdata);
        wait_rsp(r0, v.wr ? 1 : 5);
        check({tag, ".status"}, 32'(rsp_mem[r0 % 1024]), 32'(v.exp_st));
        if (!v.wr) check({tag, ".rdata"}, rsp_word(r0), v.exp_data);
        check({tag, ".nbytes"}, rsp_wr - r0, v.wr ? 1 : 5);
        check({tag, ".pen_cycles"}, pen_total - p0, v.exp_pen);
        check({tag, ".setups"}, setup_total - s0, 1);
        check({tag, ".psel_after"}, 32'(psel), 0);
        if (v.exp_st != UART_BRG_ST_TMO) begin
            check({tag, ".xfers"}, xfer_total - x0, 1);
            check({tag, ".paddr"}, cap_addr, v.addr);
            check({tag, ".pwrite"}, 32'(cap_write), 32'(v.wr));
            check({tag, ".pstrb"}, 32'(cap_strb), v.wr ? 32'hF : 32'h0);
            if (v.wr) check({tag, ".pwdata"}, cap_wdata, v.wdata);
        end else begin
            check({tag, ".xfers"}, xfer_total - x0, 0);
        end
    endtask

    vec_t vecs [0:5];

    initial begin
        int s0, r0, f0, k;
        vec_t v;

        vecs[0] = '{wr: 1, addr: 32'h40000010, wdata: 32'hDEADBEEF, rdata: 32'h0, wait_st: 0,
                    err: 0, exp_st: 8'h4B, exp_data: 32'h0, exp_pen: 1};
        vecs[1] = '{wr: 0, addr: 32'h40000004, wdata: 32'h0, rdata: 32'h12345678, wait_st: 3,
                    err: 0, exp_st: 8'h4B, exp_data: 32'h12345678, exp_pen: 4};
        vecs[2] = '{wr: 0, addr: 32'h40000008, wdata: 32'h0, rdata: 32'hCAFEF00D, wait_st: 1,
                    err: 1, exp_st: 8'h45, exp_data: 32'h0, exp_pen: 2};
        vecs[3] = '{wr: 1, addr: 32'h4000000C, wdata: 32'h01020304, rdata: 32'h0, wait_st: 0,
                    err: 1, exp_st: 8'h45, exp_data: 32'h0, exp_pen: 1};
        vecs[4] = '{wr: 0, addr: 32'h50000000, wdata: 32'h0, rdata: 32'hFFFFFFFF, wait_st: 50,
                    err: 0, exp_st: 8'h54, exp_data: 32'h0, exp_pen: 8};
        vecs[5] = '{wr: 1, addr: 32'h50000004, wdata: 32'hA5A5A5A5, rdata: 32'h0, wait_st: 50,
                    err: 0, exp_st: 8'h54, exp_data: 32'h0, exp_pen: 8};

        rx_valid = 1'b0; rx_data = 8'h00;
        slv_wait = 0; slv_err = 1'b0; slv_rdata = 32'h0;
        repeat (3) @(negedge clk);
        check("rst.psel", 32'(psel), 0);
        check("rst.penable", 32'(penable), 0);
        check("rst.tx_valid", 32'(tx_valid), 0);
        check("rst.busy", 32'(busy), 0);
        check("rst.frame_err", 32'(frame_err), 0);
        check("rst.paddr", paddr, 0);
        check("rst.pstrb_pprot", {25'd0, pstrb, pprot}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst.rx_ready", 32'(rx_ready), 1);

        for (int i = 0; i < 6; i++) apply_txn(vecs[i], $sformatf("vec%0d", i));

        // Minimum latency: first response byte two edges after the SETUP edge.
        slv_wait = 0; slv_err = 1'b0;
        r0 = rsp_wr;
        send_frame(1'b1, 32'h00000100, 32'h00000001);
        k = 0;
        while (!tx_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20) fail_bound("latency.tx_valid");
        check("latency", cyc - acc_cyc, 2);
        wait_rsp(r0, 1);
        check("latency.status", 32'(rsp_mem[r0 % 1024]), 32'h4B);

        // Inter-byte timeout mid-frame.
        s0 = setup_total; r0 = rsp_wr; f0 = fe_total;
        send_byte(8'h57);
        send_byte(8'h10);
        k = 0;
        while (!frame_err && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (k >= 60) fail_bound("btmo.pulse");
        check("btmo.cycles", cyc - acc_cyc, BTMO);
        repeat (3) @(negedge clk);
        check("btmo.fe_count", fe_total - f0, 1);
        check("btmo.setups", setup_total - s0, 0);
        check("btmo.rsp", rsp_wr - r0, 0);
        check("btmo.busy", 32'(busy), 0);
        apply_txn(vecs[0], "btmo.recover");

        // Unknown command byte in IDLE.
        s0 = setup_total; r0 = rsp_wr; f0 = fe_total;
        send_byte(8'hAA);
        repeat (3) @(negedge clk);
        check("badcmd.fe_count", fe_total - f0, 1);
        check("badcmd.setups", setup_total - s0, 0);
        check("badcmd.busy", 32'(busy), 0);
        check("badcmd.rsp", rsp_wr - r0, 0);

        // Stalled read response with a host byte pending during RESP.
        rand_mode = 1'b1;
        slv_wait = 2; slv_err = 1'b0; slv_rdata = $urandom;
        r0 = rsp_wr; f0 = fe_total;
        send_frame(1'b0, 32'h40000020, 32'h0);
        @(negedge clk);
        rx_data = 8'hAA;
        rx_valid = 1'b1;
        wait_rsp(r0, 5);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("stall.status", 32'(rsp_mem[r0 % 1024]), 32'h4B);
        check("stall.rdata", rsp_word(r0), slv_rdata);
        check("stall.held_data", stall_viol, 0);
        check("stall.rx_ready_in_resp", rxr_viol, 0);
        check("stall.late_byte_fe", fe_total - f0, 1);

        for (int i = 0; i < 30; i++) begin
            v.wr      = 1'($urandom_range(0, 1));
            v.addr    = $urandom;
            v.wdata   = $urandom;
            v.rdata   = $urandom;
            v.wait_st = $urandom_range(0, 10);
            v.err     = ($urandom_range(0, 3) == 0);
            apply_txn(model(v), $sformatf("rnd%0d", i));
        end
        check("rnd.held_data", stall_viol, 0);
        check("rnd.rx_ready_in_resp", rxr_viol, 0);
        rand_mode = 1'b0;

        // Reset asserted during ACCESS.
        slv_wait = 1000;
        r0 = rsp_wr;
        send_frame(1'b0, 32'h00002000, 32'h0);
        k = 0;
        while (!penable && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20) fail_bound("rstacc.penable");
        #2;
        rst_n = 1'b0;
        #1;
        check("rstacc.psel", 32'(psel), 0);
        check("rstacc.penable", 32'(penable), 0);
        check("rstacc.busy", 32'(busy), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("rstacc.rsp", rsp_wr - r0, 0);
        check("rstacc.rx_ready", 32'(rx_ready), 1);
        apply_txn(vecs[1], "rstacc.recover");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
